// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit and its hazard logic.
// Op codes 8-11 (accumulate ops) only count as MD operations when MD_MADD_EN is defined.
package md_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MFHI  = 4'd4;
  localparam logic [3:0] MD_MFLO  = 4'd5;
  localparam logic [3:0] MD_MTHI  = 4'd6;
  localparam logic [3:0] MD_MTLO  = 4'd7;
  localparam logic [3:0] MD_MADD  = 4'd8;
  localparam logic [3:0] MD_MADDU = 4'd9;
  localparam logic [3:0] MD_MSUB  = 4'd10;
  localparam logic [3:0] MD_MSUBU = 4'd11;

  // LO value produced by a divide with a zero divisor
  localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // True for ops that occupy the unit for several cycles
  function automatic logic is_md_busy_op(input logic [3:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MD_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

  // Divides use the longer latency; every other busy op uses the multiply latency
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit: owns HI/LO, models MULT/DIV latency with a busy counter
// and serves MFHI/MFLO reads. Define MD_MADD_EN to add MADD/MADDU/MSUB/MSUBU.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  MDctr,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Output
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      phi_q, phi_d, plo_q, plo_d;
`ifdef MD_MADD_EN
  logic             acc_q, acc_d;
  logic             sub_q, sub_d;
`endif

  logic signed [31:0] a_s, b_s, div_s;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quot_s, rem_s;
  logic        [31:0] div_u, quot_u, rem_u;

  // Operand arithmetic, evaluated behaviourally in the accept cycle
  always_comb begin
    a_s    = signed'(A);
    b_s    = signed'(B);
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'd0, A} * {32'd0, B};
    // A zero divisor is replaced by 1 so the dividers never see it (result is
    // overridden below). 0x80000000 / -1 is also divided by 1: that yields the
    // required quotient 0x80000000 and remainder 0 without signed overflow.
    if (B == 32'd0 || (A == 32'h8000_0000 && B == 32'hFFFF_FFFF)) begin
      div_s = 32'sd1;
    end else begin
      div_s = b_s;
    end
    div_u  = (B == 32'd0) ? 32'd1 : B;
    quot_s = a_s / div_s;
    rem_s  = a_s % div_s;
    quot_u = A / div_u;
    rem_u  = A % div_u;
  end

  // Next-state: count down while running, otherwise accept a new op
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
`ifdef MD_MADD_EN
    acc_d   = acc_q;
    sub_d   = sub_q;
`endif
    if (state_q == MD_RUN) begin
      count_d = count_q - CNT_W'(1);
      if (count_q == CNT_W'(1)) begin
`ifdef MD_MADD_EN
        if (acc_q) begin
          if (sub_q) begin
            {hi_d, lo_d} = {hi_q, lo_q} - {phi_q, plo_q};
          end else begin
            {hi_d, lo_d} = {hi_q, lo_q} + {phi_q, plo_q};
          end
        end else begin
          {hi_d, lo_d} = {phi_q, plo_q};
        end
`else
        {hi_d, lo_d} = {phi_q, plo_q};
`endif
      end
    end else if (start) begin
      if (is_md_busy_op(MDctr)) begin
        count_d = is_div_op(MDctr) ? DIV_LOAD : MULT_LOAD;
      end
`ifdef MD_MADD_EN
      acc_d = 1'b0;
      sub_d = 1'b0;
`endif
      case (MDctr)
        MD_MULT:  {phi_d, plo_d} = prod_s;
        MD_MULTU: {phi_d, plo_d} = prod_u;
        MD_DIV: begin
          phi_d = (B == 32'd0) ? A : rem_s;
          plo_d = (B == 32'd0) ? MD_DIV0_LO : quot_s;
        end
        MD_DIVU: begin
          phi_d = (B == 32'd0) ? A : rem_u;
          plo_d = (B == 32'd0) ? MD_DIV0_LO : quot_u;
        end
        MD_MTHI:  hi_d = A;
        MD_MTLO:  lo_d = A;
`ifdef MD_MADD_EN
        MD_MADD: begin
          {phi_d, plo_d} = prod_s;
          acc_d = 1'b1;
        end
        MD_MADDU: begin
          {phi_d, plo_d} = prod_u;
          acc_d = 1'b1;
        end
        MD_MSUB: begin
          {phi_d, plo_d} = prod_s;
          acc_d = 1'b1;
          sub_d = 1'b1;
        end
        MD_MSUBU: begin
          {phi_d, plo_d} = prod_u;
          acc_d = 1'b1;
          sub_d = 1'b1;
        end
`endif
        default: ;
      endcase
    end
    state_d = (count_d != '0) ? MD_RUN : MD_IDLE;
  end

  // State, counter, HI/LO and pending result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
`ifdef MD_MADD_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
`ifdef MD_MADD_EN
      acc_q   <= acc_d;
      sub_q   <= sub_d;
`endif
    end
  end

  // Architectural outputs and the MFHI/MFLO read mux
  always_comb begin
    busy = (state_q == MD_RUN);
    HI   = hi_q;
    LO   = lo_q;
    case (MDctr)
      MD_MFHI: Output = hi_q;
      MD_MFLO: Output = lo_q;
      default: Output = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the driver predicts HI/LO from arithmetic rules
// and queues completions; a monitor checks each busy window as it closes.
module tb_md_unit;

  localparam logic [3:0] OP_MULT = 4'd0, OP_MULTU = 4'd1, OP_DIV = 4'd2, OP_DIVU = 4'd3;
  localparam logic [3:0] OP_MFHI = 4'd4, OP_MFLO = 4'd5, OP_MTHI = 4'd6, OP_MTLO = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd9, OP_NOP = 4'd12;
`ifdef MD_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  MDctr = 4'd12;
  logic [31:0] A = '0, B = '0;
  logic        busy;
  logic [31:0] HI, LO, Output;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .MDctr(MDctr), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO), .Output(Output)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  bit          abort_flag = 1'b0;
  int          busy_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result of a multi-cycle op, from plain 64-bit arithmetic
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hilo);
    int ia, ib;
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] t;
    ia = a; ib = b; sa = ia; sb = ib; ua = a; ub = b;
    t = '0;
    case (op)
      4'd0: t = sa * sb;
      4'd1: t = ua * ub;
      4'd2: begin
        if (b == 0) t = {a, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; t = {r[31:0], q[31:0]}; end
      end
      4'd3: begin
        if (b == 0) t = {a, 32'hFFFF_FFFF};
        else begin uq = ua / ub; ur = ua % ub; t = {ur[31:0], uq[31:0]}; end
      end
      4'd8:  t = hilo + sa * sb;
      4'd9:  t = hilo + ua * ub;
      4'd10: t = hilo - sa * sb;
      4'd11: t = hilo - ua * ub;
      default: t = hilo;
    endcase
    return t;
  endfunction

  // Monitor: measure each busy window and check HI/LO as it ends
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      busy_len++;
    end else if (busy_len != 0) begin
      if (abort_flag) begin
        abort_flag = 1'b0;
      end else if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_completion: busy window of %0d cycles, none expected", busy_len);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("busy_len op%0d", e.op), 32'(busy_len), 32'(e.cycles));
        check($sformatf("HI op%0d", e.op), HI, e.hi);
        check($sformatf("LO op%0d", e.op), LO, e.lo);
      end
      busy_len = 0;
    end
  end

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: busy still %b after 40 cycles, required 0", name, busy);
    end
  endtask

  // Read HI/LO through the ports and the MF mux (called in the low clock phase)
  task automatic readback(input string name);
    check({name, "_HI"}, HI, m_hi);
    check({name, "_LO"}, LO, m_lo);
    MDctr = OP_MFHI; #1;
    check({name, "_MFHI"}, Output, m_hi);
    MDctr = OP_MFLO; #1;
    check({name, "_MFLO"}, Output, m_lo);
    MDctr = OP_NOP; #1;
    check({name, "_Out0"}, Output, 32'd0);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name, input bit finish_it);
    exp_t e;
    logic [63:0] res;
    int cyc;
    @(negedge clk);
    start = 1'b1; MDctr = op; A = a; B = b;
    cyc = 0;
    if (op <= 4'd3) cyc = (op >= 4'd2) ? 10 : 5;
    else if (op >= 4'd8 && op <= 4'd11 && MADD_ON) cyc = 5;
    if (cyc > 0) begin
      res = ref_result(op, a, b, {m_hi, m_lo});
      m_hi = res[63:32];
      m_lo = res[31:0];
      e.op = op; e.hi = m_hi; e.lo = m_lo; e.cycles = cyc;
      exp_q.push_back(e);
    end else if (op == OP_MTHI) begin
      m_hi = a;
    end else if (op == OP_MTLO) begin
      m_lo = a;
    end
    @(posedge clk);
    #1;
    start = 1'b0; MDctr = OP_NOP; A = $urandom; B = $urandom;
    check({name, "_busy_after_accept"}, {31'd0, busy}, (cyc > 0) ? 32'd1 : 32'd0);
    if (finish_it) begin
      wait_idle(name);
      readback(name);
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rb;
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rb;
    // Reset held with a start request present: nothing may be accepted
    reset_n = 1'b0; start = 1'b1; MDctr = OP_MULT; A = 32'h1234_5678; B = 32'h9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0; MDctr = OP_MULT;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_HI", HI, 32'd0);
    check("reset_LO", LO, 32'd0);
    check("reset_Output", Output, 32'd0);
    reset_n = 1'b1;

    do_op(OP_MULT,  32'hFFFF_FFFD, 32'd7, "mult_neg", 1'b1);
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, "multu", 1'b1);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, "div_neg", 1'b1);
    do_op(OP_DIVU,  32'd7, 32'd0, "divu_zero", 1'b1);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b1);
    do_op(OP_DIV,   32'hFFFF_FFF0, 32'd0, "div_zero", 1'b1);
    do_op(OP_MTHI,  32'hCAFE_0001, 32'd0, "mthi", 1'b1);
    do_op(OP_MTLO,  32'hBEEF_0002, 32'd0, "mtlo", 1'b1);
    do_op(OP_NOP,   32'h5555_5555, 32'h3, "nop12", 1'b1);
    do_op(4'd15,    32'h5555_5555, 32'h3, "nop15", 1'b1);
    do_op(4'd8,     32'h0000_0003, 32'h5, "code8", 1'b1);
    do_op(4'd11,    32'hFFFF_FFFF, 32'h2, "code11", 1'b1);

    // Accumulate into a carry boundary (only an op when the feature is built in)
    do_op(OP_MTHI,  32'd0, 32'd0, "acc_base_hi", 1'b1);
    do_op(OP_MTLO,  32'hFFFF_FFFF, 32'd0, "acc_base_lo", 1'b1);
    do_op(OP_MADDU, 32'd1, 32'd1, "maddu_carry", 1'b1);

    // MTHI presented during a MULT busy window must be ignored
    do_op(OP_MULT, 32'h1111_1111, 32'd3, "mult_mt_ignored", 1'b0);
    @(negedge clk);
    start = 1'b1; MDctr = OP_MTHI; A = 32'h1234_5678;
    @(posedge clk);
    #1;
    start = 1'b0; MDctr = OP_NOP;
    wait_idle("mult_mt_ignored");
    readback("mult_mt_ignored");

    // Reset in the middle of a DIV aborts it and clears HI/LO
    do_op(OP_DIV, 32'd100, 32'd7, "div_abort", 1'b0);
    repeat (3) @(negedge clk);
    abort_flag = 1'b1;
    exp_q.delete();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_HI", HI, 32'd0);
    check("abort_LO", LO, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_late_busy", {31'd0, busy}, 32'd0);
    check("abort_late_HI", HI, 32'd0);
    check("abort_late_LO", LO, 32'd0);

    // Random ops, including zero divisors and the most negative dividend
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      do_op(op, ra, rb, $sformatf("rand%0d_op%0d", i, op), 1'b1);
    end

    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_completions: %0d left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
